// File: rtl/store_serializer_32to8_if.sv
// Core-side store handshake plus byte-wide memory write port of the 32-to-8 store serializer.
// master = core/memory environment side, slave = serializer side.
interface store_serializer_32to8_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic              done;
    logic              misalign_err;
    logic              timeout_err;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, mem_we, mem_addr, mem_wdata, done, misalign_err, timeout_err
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, mem_we, mem_addr, mem_wdata, done, misalign_err, timeout_err
    );
endinterface

// File: rtl/store_serializer_32to8.sv
// Splits one SB/SH/SW store into little-endian byte writes on an 8-bit memory port.
// Optional macro SER_TIMEOUT_EN adds a per-byte mem_ack timeout with abort (timeout_err).
module store_serializer_32to8 #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    store_serializer_32to8_if.slave bus
);
    // TOUT is only reachable when the ack timeout is compiled in.
    typedef enum logic [2:0] {IDLE, SEND, DONE, ERR, TOUT} state_t;

    state_t            state_q, state_nx;
    logic [1:0]        cnt_q;
    logic [1:0]        last_q;
    logic [1:0]        last_nx;
    logic              misaligned;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("store_serializer_32to8: TIMEOUT_CYCLES must be at least 1");
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        last_nx    = 2'd0;
        misaligned = 1'b0;
        case (bus.st_size)
            2'b00:   last_nx = 2'd0;
            2'b01: begin
                last_nx    = 2'd1;
                misaligned = bus.st_addr[0];
            end
            2'b10: begin
                last_nx    = 2'd3;
                misaligned = |bus.st_addr[1:0];
            end
            default: misaligned = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, sampled on clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_nx;
            if (state_q == IDLE && bus.st_valid) begin
                addr_q <= bus.st_addr;
                data_q <= bus.st_data;
                last_q <= last_nx;
                cnt_q  <= 2'd0;
            end else if (state_q == SEND && bus.mem_ack && cnt_q != last_q) begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

`ifdef SER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q;
    logic              wait_expired;

    // Counts consecutive ack-less SEND cycles for the byte currently on the bus.
    always_ff @(posedge clk) begin
        if (rst || state_q != SEND || bus.mem_ack) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + 1'b1;
        end
    end

    assign wait_expired = !bus.mem_ack && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_nx         = state_q;
        bus.st_ready     = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = 8'h00;
        bus.done         = 1'b0;
        bus.misalign_err = 1'b0;
        bus.timeout_err  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.st_ready = 1'b1;
                if (bus.st_valid) begin
                    state_nx = misaligned ? ERR : SEND;
                end
            end
            SEND: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q + ADDR_W'(cnt_q);
                bus.mem_wdata = data_q[{cnt_q, 3'b000} +: 8];
                if (bus.mem_ack) begin
                    if (cnt_q == last_q) begin
                        state_nx = DONE;
                    end
                end
`ifdef SER_TIMEOUT_EN
                else if (wait_expired) begin
                    state_nx = TOUT;
                end
`endif
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                bus.done         = 1'b1;
                bus.misalign_err = 1'b1;
                state_nx         = IDLE;
            end
            TOUT: begin
                bus.done = 1'b1;
`ifdef SER_TIMEOUT_EN
                bus.timeout_err = 1'b1;
`endif
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_store_serializer_32to8.sv
// Self-checking bench for store_serializer_32to8: table vectors, corner sequences and random stores
// against a byte-list reference model. Honours SER_TIMEOUT_EN for the ack-timeout sequence.
`timescale 1ns/1ps
module tb_store_serializer_32to8;
    localparam int ADDR_W = 32;
    localparam int TO     = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          ack_every;
        int          lat;
        logic        merr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_serializer_32to8_if #(.ADDR_W(ADDR_W)) bus ();

    store_serializer_32to8 #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  total = 0;
    int  bad   = 0;
    wr_t wq[$];
    wr_t exp_q[$];
    int  we_cycles = 0;

    // Memory-side observer: every acked byte and every cycle with a write request.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.mem_we) we_cycles++;
            if (bus.mem_we && bus.mem_ack) wq.push_back({bus.mem_addr, bus.mem_wdata});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a store is a list of (address, byte) writes or a rejection.
    function automatic void model(input logic [1:0] size, input logic [31:0] addr,
                                  input logic [31:0] data, output logic err, output int n);
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % 32'(n)) != 0);
        exp_q.delete();
        if (!err) begin
            for (int k = 0; k < n; k++) begin
                exp_q.push_back('{a: addr + 32'(k), d: 8'(data >> (8 * k))});
            end
        end
    endfunction

    // ack_every > 0: ack on every ack_every-th cycle; 0: random ack (never 3 misses in a row).
    task automatic run_req(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input int ack_every,
                           output int lat, output logic merr);
        logic        exp_err, a, pwait, dirty, unstable, terr;
        logic [31:0] pa;
        logic [7:0]  pd;
        int          n, acks, exp_lat, zrun;
        model(size, addr, data, exp_err, n);
        wq.delete();
        we_cycles = 0;
        dirty = 0; unstable = 0; pwait = 0; terr = 0;
        acks = 0; zrun = 0; lat = -1; merr = 0;
        pa = '0; pd = '0;
        exp_lat = exp_err ? 1 : -1;
        for (int i = 0; i < 20 && !bus.st_ready; i++) step();
        check({tag, " ready"}, bus.st_ready, 1);
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_size  = size;
        bus.mem_ack  = 1'($urandom % 2);
        step();
        bus.st_valid = 1'b0;
        bus.st_data  = $urandom;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (bus.done) begin
                lat  = cyc;
                merr = bus.misalign_err;
                terr = bus.timeout_err;
                break;
            end
            if (!bus.mem_we && (bus.mem_addr != 0 || bus.mem_wdata != 0)) dirty = 1;
            if (pwait && bus.mem_we && (bus.mem_addr !== pa || bus.mem_wdata !== pd)) unstable = 1;
            if (ack_every > 0) a = (cyc % ack_every) == 0;
            else               a = 1'($urandom % 2) || (zrun >= 2);
            zrun = a ? 0 : zrun + 1;
            bus.mem_ack = a;
            if (!exp_err && a && acks < n) begin
                acks++;
                if (acks == n) exp_lat = cyc + 1;
            end
            pwait = bus.mem_we && !a;
            pa    = bus.mem_addr;
            pd    = bus.mem_wdata;
            step();
        end
        check({tag, " lat"}, lat, exp_lat);
        check({tag, " misalign_err"}, merr, exp_err);
        check({tag, " timeout_err"}, terr, 0);
        check({tag, " nwrites"}, wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s write%0d", tag, i), wq[i], exp_q[i]);
        end
        check({tag, " we_cycles"}, we_cycles, exp_err ? 0 : lat - 1);
        check({tag, " idle_bus_zero"}, dirty, 0);
        check({tag, " held_while_waiting"}, unstable, 0);
        bus.mem_ack = 1'b0;
        step();
        check({tag, " done_one_cycle"}, bus.done, 0);
        check({tag, " back_to_idle"}, bus.st_ready, 1);
    endtask

    vec_t vt[9];

    initial begin
        int          lat, steps;
        logic        merr, seen_done;
        logic [1:0]  rsize;
        logic [31:0] raddr;

        vt[0] = '{2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 1, 5, 1'b0};
        vt[1] = '{2'b01, 32'h0000_0202, 32'h1234_ABCD, 3, 7, 1'b0};
        vt[2] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0069, 1, 2, 1'b0};
        vt[3] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0069, 1, 1, 1'b1};
        vt[4] = '{2'b11, 32'h0000_0000, 32'hCAFE_F00D, 1, 1, 1'b1};
        vt[5] = '{2'b10, 32'hFFFF_FFFE, 32'h0BAD_CAFE, 1, 1, 1'b1};
        vt[6] = '{2'b01, 32'hFFFF_FFFE, 32'hA5A5_1357, 1, 3, 1'b0};
        vt[7] = '{2'b00, 32'h0000_0003, 32'hFFFF_FF80, 1, 2, 1'b0};
        vt[8] = '{2'b10, 32'hFFFF_FFFC, 32'h8877_6655, 2, 9, 1'b0};

        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_size  = 2'b00;
        bus.mem_ack  = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst st_ready", bus.st_ready, 1);
        check("rst mem_we", bus.mem_we, 0);
        check("rst mem_addr", bus.mem_addr, 0);
        check("rst mem_wdata", bus.mem_wdata, 0);
        check("rst done", bus.done, 0);
        check("rst errs", {bus.misalign_err, bus.timeout_err}, 0);
        rst = 1'b0;

        // Reset in the middle of a word store stalled on ack.
        bus.st_valid = 1'b1; bus.st_size = 2'b10; bus.st_addr = 32'h100; bus.st_data = 32'hDEADBEEF;
        step();
        bus.st_valid = 1'b0;
        step();
        check("midrst pre mem_we", bus.mem_we, 1);
        check("midrst pre mem_addr", bus.mem_addr, 32'h100);
        rst = 1'b1;
        step();
        check("midrst mem_we", bus.mem_we, 0);
        check("midrst st_ready", bus.st_ready, 1);
        check("midrst done", bus.done, 0);
        check("midrst mem_addr", bus.mem_addr, 0);
        check("midrst mem_wdata", bus.mem_wdata, 0);
        step();
        check("midrst done2", bus.done, 0);
        check("midrst errs", {bus.misalign_err, bus.timeout_err}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            run_req($sformatf("vec%0d", i), vt[i].size, vt[i].addr, vt[i].data, vt[i].ack_every, lat, merr);
            check($sformatf("vec%0d tbl_lat", i), lat, vt[i].lat);
            check($sformatf("vec%0d tbl_merr", i), merr, vt[i].merr);
        end

        // st_valid held through SEND with new contents: only taken on the first IDLE cycle after done.
        wq.delete();
        bus.st_valid = 1'b1; bus.st_size = 2'b10; bus.st_addr = 32'h400; bus.st_data = 32'h11223344;
        bus.mem_ack = 1'b1;
        step();
        bus.st_addr = 32'h500; bus.st_data = 32'h55667788;
        steps = 0;
        while (!bus.done && steps < 50) begin step(); steps++; end
        check("hold lat", steps + 1, 5);
        step();
        check("hold idle st_ready", bus.st_ready, 1);
        check("hold idle mem_we", bus.mem_we, 0);
        step();
        bus.st_valid = 1'b0;
        check("hold second mem_addr", bus.mem_addr, 32'h500);
        check("hold second mem_wdata", bus.mem_wdata, 8'h88);
        steps = 0;
        while (!bus.done && steps < 50) begin step(); steps++; end
        check("hold second done", bus.done, 1);
        bus.mem_ack = 1'b0;
        step();
        check("hold nwrites", wq.size(), 8);
        if (wq.size() == 8) begin
            check("hold w0", wq[0], {32'h400, 8'h44});
            check("hold w3", wq[3], {32'h403, 8'h11});
            check("hold w4", wq[4], {32'h500, 8'h88});
            check("hold w7", wq[7], {32'h503, 8'h55});
        end

        // Ack only for byte 0 of a word store.
        wq.delete();
        bus.st_valid = 1'b1; bus.st_size = 2'b10; bus.st_addr = 32'h600; bus.st_data = 32'hA1B2C3D4;
        bus.mem_ack = 1'b0;
        step();
        bus.st_valid = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
`ifdef SER_TIMEOUT_EN
        steps = 0;
        while (!bus.done && steps < 40) begin step(); steps++; end
        check("tout waits", steps, TO);
        check("tout timeout_err", bus.timeout_err, 1);
        check("tout misalign_err", bus.misalign_err, 0);
        check("tout mem_we", bus.mem_we, 0);
        check("tout nwrites", wq.size(), 1);
        step();
        check("tout done_one_cycle", bus.done, 0);
        check("tout st_ready", bus.st_ready, 1);
`else
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done) seen_done = 1'b1;
        end
        check("noto done", seen_done, 0);
        check("noto mem_we", bus.mem_we, 1);
        check("noto mem_addr", bus.mem_addr, 32'h601);
        check("noto mem_wdata", bus.mem_wdata, 8'hC3);
        check("noto nwrites", wq.size(), 1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("noto recover st_ready", bus.st_ready, 1);
`endif
        step();

        for (int i = 0; i < 60; i++) begin
            rsize = 2'($urandom % 4);
            raddr = ($urandom % 4 == 0) ? 32'hFFFF_FFFC + 32'($urandom % 4) : 32'($urandom);
            run_req($sformatf("rnd%0d", i), rsize, raddr, 32'($urandom),
                    ($urandom % 3 == 0) ? 0 : 1 + int'($urandom % 3), lat, merr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
